stochastic_to_binary: RTL and testbench

//  Downstream stage of stochastic_adder: turns its serial output stream y into a binary count.

---
 rtl/sc_pkg.sv | 20 ++
 rtl/sc_window_counter.sv | 48 ++++
 rtl/stochastic_to_binary.sv | 103 ++++++++++
 tb/tb_stochastic_to_binary.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing blocks.
// Used by the adder bench and the stream-to-binary converter.
package sc_pkg;

  localparam int BIT_LENGTH_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Bit-index and ones counter over one window of valid stream bits.
// ones_nxt includes the current bit so the final bit can be captured.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF,
  parameter int CNT_W      = clog2(BIT_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic             last,
  output logic [CNT_W-1:0] ones_nxt
);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ones_q, ones_d;

  assign last     = (idx_q == CNT_W'(BIT_LENGTH - 1));
  assign ones_nxt = ones_q + CNT_W'(bit_in);

  // next index/count: clear wins, otherwise advance on each valid bit
  always_comb begin
    idx_d  = idx_q;
    ones_d = ones_q;
    if (clr) begin
      idx_d  = '0;
      ones_d = '0;
    end else if (en) begin
      idx_d  = idx_q + CNT_W'(1);
      ones_d = ones_nxt;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      ones_q <= '0;
    end else begin
      idx_q  <= idx_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/stochastic_to_binary.sv
// Counts ones over a window of the adder's y stream and hands the
// (optionally rescaled) count to the next stage over valid/ready.
module stochastic_to_binary
  import sc_pkg::*;
#(
  parameter int BIT_LENGTH  = BIT_LENGTH_DEF,
  parameter int CNT_W       = clog2(BIT_LENGTH + 1),
  parameter int SCALE_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         busy,
  output logic [CNT_W-1:0]             count_out,
  output logic [CNT_W+SCALE_SHIFT-1:0] value_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun
);

  localparam int VW = CNT_W + SCALE_SHIFT;

  sc_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [VW-1:0]    value_q, value_d;
  logic             valid_q, valid_d;
  logic             clr, en, last;
  logic [CNT_W-1:0] ones_nxt;

  sc_window_counter #(
    .BIT_LENGTH(BIT_LENGTH),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (en),
    .bit_in  (bit_in),
    .last    (last),
    .ones_nxt(ones_nxt)
  );

  assign busy      = (state_q == ACCUM);
  assign overrun   = (state_q == DONE) && bit_valid;
  assign count_out = count_q;
  assign value_out = value_q;
  assign out_valid = valid_q;

  // window FSM: capture result on the last bit, hold it until accepted
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = valid_q;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        en = bit_valid;
        if (bit_valid && last) begin
          count_d = ones_nxt;
          value_d = VW'(ones_nxt) << SCALE_SHIFT;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_stochastic_to_binary.sv
// Scoreboard bench for stochastic_to_binary.
// Expected counts are queued when a window is driven, checked on output.
module tb_stochastic_to_binary;

  localparam int BL = 128;
  localparam int CW = 8;
  localparam int SS = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          busy;
  logic [CW-1:0] count_out;
  logic [CW:0]   value_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  stochastic_to_binary #(
    .BIT_LENGTH (BL),
    .CNT_W      (CW),
    .SCALE_SHIFT(SS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .busy     (busy),
    .count_out(count_out),
    .value_out(value_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_bits(input logic [BL-1:0] bits,
                          input bit gaps,
                          input bit stray);
    int sent;
    int c;
    bit busy_drop;
    sent = 0;
    c = 0;
    busy_drop = 0;
    start_win();
    while (sent < BL) begin
      start = stray && sent >= 40 && sent < 43;
      out_ready = stray && sent < 10;
      if (gaps && (c % 3 == 2)) begin
        bit_valid = 1'b0;
        cyc();
      end else begin
        if (sent == BL - 1) begin
          check("pre_last_valid", out_valid, 0);
          exp_q.push_back($countones(bits));
        end
        bit_valid = 1'b1;
        bit_in = bits[sent];
        cyc();
        sent++;
      end
      c++;
      if (sent < BL && !busy) busy_drop = 1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    bit_valid = 1'b0;
    check("busy_thru_window", busy_drop, 0);
    check("latency_1", out_valid, 1);
  endtask

  task automatic take_result(input bit start_on_hs);
    int n;
    int e;
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("count_out", count_out, e);
    check("value_out", value_out, e << SS);
    out_ready = 1'b1;
    start = start_on_hs;
    cyc();
    out_ready = 1'b0;
    start = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_after_hs", busy, 0);
  endtask

  logic [BL-1:0] pat;
  logic [BL-1:0] a_b, b_b, s_b;

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_count", count_out, 0);
    check("rst_value", value_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    #12 rst_n = 1'b1;
    cyc();

    // 1: all ones
    pat = '1;
    run_bits(pat, 1'b0, 1'b0);
    take_result(1'b0);

    // 2: alternating 1,0 with a gap every third cycle
    for (int i = 0; i < BL; i++) pat[i] = (i % 2 == 0);
    run_bits(pat, 1'b1, 1'b0);
    take_result(1'b0);

    // 3: consumer stalls, stray bits in DONE
    for (int i = 0; i < BL; i++) pat[i] = 1'($urandom_range(0, 1));
    run_bits(pat, 1'b0, 1'b0);
    begin
      int ovr;
      bit moved;
      logic [CW-1:0] c0;
      ovr = 0;
      moved = 0;
      c0 = count_out;
      for (int k = 0; k < 10; k++) begin
        bit_valid = (k % 3 == 2);
        #1;
        if (overrun) ovr++;
        cyc();
        if (count_out !== c0 || !out_valid) moved = 1;
      end
      bit_valid = 1'b0;
      check("stall_stable", moved, 0);
      check("overrun_pulses", ovr, 3);
    end
    take_result(1'b0);
    bit_valid = 1'b1;
    #1;
    check("idle_no_overrun", overrun, 0);
    cyc();
    bit_valid = 1'b0;
    check("idle_ignores_bits", busy, 0);

    // 4: reset mid-window, then an all-zero window
    start_win();
    for (int i = 0; i < 50; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      cyc();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_count", count_out, 0);
    check("arst_value", value_out, 0);
    check("arst_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pat = '0;
    run_bits(pat, 1'b0, 1'b0);
    take_result(1'b0);

    // 5: start mid-window and on the handshake is ignored
    pat = '1;
    run_bits(pat, 1'b0, 1'b1);
    take_result(1'b1);
    cyc();
    check("start_on_hs_ignored", busy, 0);

    // 6: adder-fed rows, y = sel ? a : b
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < BL; i++) begin
        a_b[i] = 1'($urandom_range(0, 1));
        b_b[i] = 1'($urandom_range(0, 1));
        s_b[i] = 1'($urandom_range(0, 1));
        pat[i] = s_b[i] ? a_b[i] : b_b[i];
      end
      run_bits(pat, r[0], 1'b0);
      take_result(1'b0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
